// File: rtl/varicode_pkg.sv
// Shared constants and state encoding for the PSK31 varicode deframer.
package varicode_pkg;

    localparam int VARICODE_W_DEFAULT = 10;
    // Two consecutive zeros separate varicode symbols.
    localparam int SEP_ZEROS = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESYNC  = 2'd2
    } state_e;

endpackage

// File: rtl/varicode_deframer.sv
// Splits a demodulated PSK31 bit stream into varicode symbols on "00" separators,
// emitting each symbol right-aligned with a one-cycle code_valid strobe.
module varicode_deframer
    import varicode_pkg::*;
#(
    parameter int VARICODE_W = VARICODE_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [VARICODE_W-1:0] varicode,
    output logic                  code_valid,
    output logic                  overflow_err
);

    localparam int LEN_W = $clog2(VARICODE_W + 3);
    localparam int ZC_W  = $clog2(SEP_ZEROS + 1);

    state_e                state_q, state_d;
    logic [VARICODE_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  pz_q, pz_d;
    logic [ZC_W-1:0]       zcnt_q, zcnt_d;
    logic                  emit, ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            len_q        <= '0;
            pz_q         <= 1'b0;
            zcnt_q       <= '0;
            varicode     <= '0;
            code_valid   <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            len_q        <= len_d;
            pz_q         <= pz_d;
            zcnt_q       <= zcnt_d;
            code_valid   <= emit;
            overflow_err <= ovf;
            if (emit) begin
                varicode <= shreg_q;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d = state_q;
        shreg_d = shreg_q;
        len_d   = len_q;
        pz_d    = pz_q;
        zcnt_d  = zcnt_q;
        emit    = 1'b0;
        ovf     = 1'b0;

        if (bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (bit_in) begin
                        shreg_d = VARICODE_W'(1);
                        len_d   = LEN_W'(1);
                        pz_d    = 1'b0;
                        state_d = COLLECT;
                    end
                end

                COLLECT: begin
                    if (!pz_q && !bit_in) begin
                        pz_d = 1'b1;
                    end else if (pz_q && !bit_in) begin
                        emit    = 1'b1;
                        shreg_d = '0;
                        len_d   = '0;
                        pz_d    = 1'b0;
                        state_d = IDLE;
                    end else if ((!pz_q && len_q > LEN_W'(VARICODE_W - 1)) ||
                                 ( pz_q && len_q > LEN_W'(VARICODE_W - 2))) begin
                        // Symbol would not fit: drop it and wait for a clean separator.
                        ovf     = 1'b1;
                        shreg_d = '0;
                        len_d   = '0;
                        pz_d    = 1'b0;
                        zcnt_d  = '0;
                        state_d = RESYNC;
                    end else if (!pz_q) begin
                        shreg_d = (shreg_q << 1) | VARICODE_W'(1);
                        len_d   = len_q + LEN_W'(1);
                    end else begin
                        // A lone deferred zero was an in-symbol zero: insert "01" at once.
                        shreg_d = (shreg_q << 2) | VARICODE_W'(1);
                        len_d   = len_q + LEN_W'(2);
                        pz_d    = 1'b0;
                    end
                end

                RESYNC: begin
                    if (bit_in) begin
                        zcnt_d = '0;
                    end else if (zcnt_q == ZC_W'(SEP_ZEROS - 1)) begin
                        zcnt_d  = '0;
                        state_d = IDLE;
                    end else begin
                        zcnt_d = zcnt_q + ZC_W'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/varicode_deframer.md
VARICODE_DEFRAMER -- requirements
Module: varicode_deframer

Interface
REQ-001 SHALL declare parameter VARICODE_W, default 10, maximum varicode symbol length in bits.
REQ-002 SHALL declare port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL declare port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL declare port bit_in, input, 1, demodulated PSK31 data bit.
REQ-005 SHALL declare port bit_valid, input, 1, qualifies bit_in; may be high on any cycle, including consecutive cycles.
REQ-006 SHALL declare port varicode, output, VARICODE_W, assembled symbol, right-aligned, MSB-first order as received, separator zeros stripped, zero-extended.
REQ-007 SHALL declare port code_valid, output, 1, one-cycle strobe marking a new varicode word; drives the downstream lookup enable.
REQ-008 SHALL declare port overflow_err, output, 1, one-cycle strobe marking a symbol longer than VARICODE_W.

Function
REQ-009 SHALL act only on cycles with bit_valid=1; with bit_valid=0 all state holds and strobes are 0.
REQ-010 SHALL implement states IDLE, COLLECT, RESYNC.
REQ-011 IDLE: bit 0 ignored; bit 1 -> load shift register with 1, length=1, pending_zero=0, go COLLECT.
REQ-012 COLLECT, bit 1, pending_zero=0: shift in 1, length+1.
REQ-013 COLLECT, bit 0, pending_zero=0: set pending_zero; no shift.
REQ-014 COLLECT, bit 1, pending_zero=1: shift in "01" in one cycle, length+2, clear pending_zero.
REQ-015 COLLECT, bit 0, pending_zero=1: "00" separator; register shift register onto varicode, pulse code_valid, go IDLE.
REQ-016 Any shift that would make length exceed VARICODE_W SHALL discard the symbol, pulse overflow_err, and go RESYNC; code_valid stays 0.
REQ-017 RESYNC: wait for two consecutive valid 0 bits, then go IDLE; no code_valid pulses in RESYNC.
REQ-018 code_valid and overflow_err SHALL assert in the cycle after the qualifying bit_valid cycle (latency 1) and last exactly 1 cycle.
REQ-019 varicode SHALL hold its last value until the next code_valid.
REQ-020 A symbol of exactly VARICODE_W bits SHALL be accepted without error.
REQ-021 Length counter width SHALL hold VARICODE_W+2 without wrap.

Reset
REQ-022 rst_n=0 SHALL asynchronously force state=IDLE, shift register=0, length=0, pending_zero=0, varicode=0, code_valid=0, overflow_err=0.
REQ-023 Reset mid-symbol SHALL discard partial bits; no strobe is generated by reset or its release.
REQ-024 The first valid bit after reset release SHALL be processed as in IDLE.

Structure
REQ-025 Package varicode_pkg SHALL hold VARICODE_W default, state encoding constants, and a two-zero separator length constant.
REQ-026 Implementation SHALL be a single module with no sub-modules; downstream lookup is instantiated by the parent, code_valid to its enable.

Verification
REQ-027 Bits 1,1,0,0 back-to-back -> varicode=10'b0000000011 ('e'), code_valid high one cycle, one cycle after the last 0.
REQ-028 Bits 1,0,1,0,1,1,0,0 with bit_valid gaps of 3 idle cycles -> single code_valid, varicode=10'b0000101011 ('h').
REQ-029 Bits 1,0,0 -> varicode=10'b0000000001 (space); leading zeros 0,0,0 before it produce no strobe.
REQ-030 Eleven 1s -> overflow_err pulse on 11th bit, no code_valid; then 0,0,1,0,1,1,0,0 -> varicode=10'b0000001011 ('a').
REQ-031 Ten-bit 1,0,1,1,0,1,0,1,0,1 then 0,0 -> varicode=10'b1011010101 ('%'), no overflow_err.
REQ-032 Bits 1,1,1 then rst_n low 1 cycle, then 1,0,1,0,0 -> exactly one code_valid, varicode=10'b0000000101 ('t').
